blinkt_led_streamer: RTL

Parametrised successor to the Blinkt LED-bar Wishbone peripheral. It holds NUM_LEDS 32-bit LED words in Wishbone-writable registers. On command it streams an APA102-style frame over AXI-Stream: start words, then LED words, then end words. Unlike the previous block, it has a full valid/ready handshake, TLAST, pending/auto-repeat triggering, byte-select writes, a frame counter and error response on unmapped addresses. It sits between the serial Wishbone bridge and the SPI/AXIS shifter.

---
 rtl/blinkt_led_streamer_if.sv | 32 +++
 rtl/blinkt_led_streamer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/blinkt_led_streamer_if.sv
// Bus bundle for blinkt_led_streamer: Wishbone register port plus AXI-Stream LED frame output.
// The slave modport is the peripheral's view; master is the bridge/shifter side.
interface blinkt_led_streamer_if #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0]   wb_adr_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH-1:0]   wb_dat_o;
   logic                    wb_we_i;
   logic [SELECT_WIDTH-1:0] wb_sel_i;
   logic                    wb_stb_i;
   logic                    wb_cyc_i;
   logic                    wb_ack_o;
   logic                    wb_err_o;
   logic                    wb_rty_o;
   logic [31:0]             m_axis_data;
   logic                    m_axis_valid;
   logic                    m_axis_last;
   logic                    s_axis_ready;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i, s_axis_ready,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, m_axis_data, m_axis_valid, m_axis_last
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i, s_axis_ready,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, m_axis_data, m_axis_valid, m_axis_last
   );
endinterface

// File: rtl/blinkt_led_streamer.sv
// Wishbone-programmable LED word bank streamed as an APA102-style frame over AXI-Stream.
// Frames: START_WORDS zero words, NUM_LEDS LED words, END_WORDS all-ones words (TLAST on the final one).
module blinkt_led_streamer #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned NUM_LEDS     = 8,
   parameter int unsigned START_WORDS  = 1,
   parameter int unsigned END_WORDS    = 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   blinkt_led_streamer_if.slave bus
);
   localparam int unsigned MAX_SE    = (START_WORDS > END_WORDS) ? START_WORDS : END_WORDS;
   localparam int unsigned MAX_BEATS = (MAX_SE > NUM_LEDS) ? MAX_SE : NUM_LEDS;
   localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WORDS - 1);
   localparam logic [CNT_W-1:0] LEDS_LAST  = CNT_W'(NUM_LEDS - 1);
   localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_WORDS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_LEDS, ST_END} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
   logic                    pending_q, pending_d;
   logic                    repeat_q, repeat_d;
   logic [15:0]             frame_cnt_q, frame_cnt_d;
   logic                    ack_q, ack_d, err_q, err_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d, rd_data;
   logic [31:0]             data_q, data_d, led_next;
   logic                    valid_q, valid_d, last_q, last_d;
   logic [31:0]             led_q [NUM_LEDS];
   logic [31:0]             led_d [NUM_LEDS];

   logic [11:0] adr;
   logic [5:0]  led_idx;
   logic        accept, is_ctrl, is_status, is_led, hit, start_wr, hs, enter_start;
   logic        unused_adr;

   assign adr        = bus.wb_adr_i[11:0];
   assign led_idx    = adr[7:2];
   assign unused_adr = ^bus.wb_adr_i[ADDR_WIDTH-1:12];

   assign accept    = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q & ~err_q;
   assign is_ctrl   = (adr == 12'h000);
   assign is_status = (adr == 12'h004);
   assign is_led    = (adr[11:8] == 4'h1) && (adr[1:0] == 2'b00) && ({26'd0, led_idx} < NUM_LEDS);
   assign hit       = is_ctrl | is_status | is_led;
   assign start_wr  = accept & bus.wb_we_i & is_ctrl & bus.wb_dat_i[0];
   assign hs        = valid_q & bus.s_axis_ready;
   assign cnt_inc   = cnt_q + CNT_W'(1);

   // Wishbone side: decode, read mux, register writes
   always_comb begin
      rd_data  = '0;
      repeat_d = repeat_q;
      for (int unsigned k = 0; k < NUM_LEDS; k++) led_d[k] = led_q[k];
      if (is_ctrl)   rd_data = {29'd0, repeat_q, pending_q, state_q != ST_IDLE};
      if (is_status) rd_data = {frame_cnt_q, 8'h00, 8'(NUM_LEDS)};
      if (is_led) begin
         for (int unsigned k = 0; k < NUM_LEDS; k++)
            if (led_idx == 6'(k)) rd_data = led_q[k];
      end
      if (accept && bus.wb_we_i && is_ctrl) repeat_d = bus.wb_dat_i[1];
      if (accept && bus.wb_we_i && is_led) begin
         for (int unsigned k = 0; k < NUM_LEDS; k++) begin
            if (led_idx == 6'(k)) begin
               for (int unsigned b = 0; b < SELECT_WIDTH; b++)
                  if (bus.wb_sel_i[b]) led_d[k][8*b +: 8] = bus.wb_dat_i[8*b +: 8];
            end
         end
      end
      ack_d = accept & hit;
      err_d = accept & ~hit;
      dat_d = (accept & hit) ? rd_data : '0;
   end

   // Stream side: the next beat is registered on the handshake of the current one,
   // so LED words are sampled live at presentation time and then held.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      data_d      = data_q;
      last_d      = last_q;
      pending_d   = pending_q;
      frame_cnt_d = frame_cnt_q;
      enter_start = 1'b0;
      led_next    = '0;
      for (int unsigned k = 0; k < NUM_LEDS; k++)
         if (cnt_inc == CNT_W'(k)) led_next = led_q[k];

      case (state_q)
         ST_IDLE: if (pending_q) enter_start = 1'b1;
         ST_START: if (hs) begin
            if (cnt_q == START_LAST) begin
               state_d = ST_LEDS;
               cnt_d   = '0;
               data_d  = {3'b111, led_q[0][28:0]};
            end else begin
               cnt_d  = cnt_inc;
               data_d = '0;
            end
         end
         ST_LEDS: if (hs) begin
            if (cnt_q == LEDS_LAST) begin
               state_d = ST_END;
               cnt_d   = '0;
               data_d  = '1;
               last_d  = (END_WORDS == 1);
            end else begin
               cnt_d  = cnt_inc;
               data_d = {3'b111, led_next[28:0]};
            end
         end
         ST_END: if (hs) begin
            if (cnt_q == END_LAST) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               if (pending_q || repeat_q) begin
                  enter_start = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  data_d  = '0;
                  last_d  = 1'b0;
               end
            end else begin
               cnt_d  = cnt_inc;
               data_d = '1;
               last_d = (cnt_inc == END_LAST);
            end
         end
      endcase

      if (enter_start) begin
         state_d   = ST_START;
         cnt_d     = '0;
         valid_d   = 1'b1;
         data_d    = '0;
         last_d    = 1'b0;
         pending_d = 1'b0;
      end
      if (start_wr) pending_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         repeat_q    <= 1'b0;
         frame_cnt_q <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         for (int unsigned k = 0; k < NUM_LEDS; k++) led_q[k] <= 32'hE000_0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         repeat_q    <= repeat_d;
         frame_cnt_q <= frame_cnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         dat_q       <= dat_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         for (int unsigned k = 0; k < NUM_LEDS; k++) led_q[k] <= led_d[k];
      end
   end

   assign bus.wb_ack_o     = ack_q;
   assign bus.wb_err_o     = err_q;
   assign bus.wb_rty_o     = 1'b0;
   assign bus.wb_dat_o     = dat_q;
   assign bus.m_axis_data  = data_q;
   assign bus.m_axis_valid = valid_q;
   assign bus.m_axis_last  = last_q;
endmodule
